bus_snoop_ctrl: RTL and testbench

BUS_SNOOP_CTRL -- requirements
Module: bus_snoop_ctrl

---
 rtl/bus_snoop_ctrl.sv | 163 ++++++++++++++++
 tb/tb_bus_snoop_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_snoop_ctrl.sv
// Snoop controller for a two-line write-back cache: watches foreign bus misses and
// invalidates, writes back dirty data when needed, and updates the affected line state.
module bus_snoop_ctrl (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [5:0] bus_in,
    input  logic       bus_own,
    input  logic [1:0] cb0_state,
    input  logic [1:0] cb1_state,
    input  logic [2:0] cb0_addr,
    input  logic [2:0] cb1_addr,
    input  logic [3:0] cb0_data,
    input  logic [3:0] cb1_data,
    input  logic       wb_ready,
    output logic       wb_valid,
    output logic [2:0] wb_addr,
    output logic [3:0] wb_data,
    output logic [1:0] state_we,
    output logic [1:0] state_new,
    output logic       abort,
    output logic       snoop_done,
    output logic       busy,
    output logic       protocol_err
);

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_WR   = 2'b10;
    localparam logic [1:0] OP_INV  = 2'b11;

    localparam logic [1:0] ST_I = 2'b00;
    localparam logic [1:0] ST_S = 2'b01;
    localparam logic [1:0] ST_M = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LOOKUP = 2'b01,
        WB     = 2'b10,
        FINISH = 2'b11
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] op_q, op_d;
    logic [2:0] addr_q, addr_d;
    logic       hit_q, hit_d;
    logic       dirty_q, dirty_d;
    logic [3:0] data_q, data_d;

    logic [1:0] sel_state;
    logic [2:0] sel_addr;
    logic [3:0] sel_data;
    logic       look_hit;
    logic       look_dirty;
    logic       accept;

    // Line selection is by the low address bit; reserved state 11 never hits.
    always_comb begin
        sel_state  = addr_q[0] ? cb1_state : cb0_state;
        sel_addr   = addr_q[0] ? cb1_addr  : cb0_addr;
        sel_data   = addr_q[0] ? cb1_data  : cb0_data;
        look_hit   = (sel_addr == addr_q) && ((sel_state == ST_S) || (sel_state == ST_M));
        look_dirty = look_hit && (sel_state == ST_M);
    end

    assign accept = bus_in[5] && (bus_in[4:3] != OP_NONE) && !bus_own;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            op_q    <= OP_NONE;
            addr_q  <= 3'b000;
            hit_q   <= 1'b0;
            dirty_q <= 1'b0;
            data_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            hit_q   <= hit_d;
            dirty_q <= dirty_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        hit_d        = hit_q;
        dirty_d      = dirty_q;
        data_d       = data_q;
        wb_valid     = 1'b0;
        wb_addr      = 3'b000;
        wb_data      = 4'b0000;
        state_we     = 2'b00;
        state_new    = ST_I;
        abort        = 1'b0;
        snoop_done   = 1'b0;
        protocol_err = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = bus_in[4:3];
                    addr_d  = bus_in[2:0];
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                hit_d   = look_hit;
                dirty_d = look_dirty;
                data_d  = sel_data;
                // Dirty lines hit by an invalidate are flagged, not written back.
                if (look_dirty && (op_q != OP_INV)) begin
                    state_d = WB;
                end else begin
                    state_d = FINISH;
                end
            end
            WB: begin
                wb_valid = 1'b1;
                wb_addr  = addr_q;
                wb_data  = data_q;
                if (wb_ready) begin
                    abort   = 1'b1;
                    state_d = FINISH;
                end
            end
            FINISH: begin
                snoop_done = 1'b1;
                state_d    = IDLE;
                if (hit_q) begin
                    case (op_q)
                        OP_RD: begin
                            if (dirty_q) begin
                                state_we  = addr_q[0] ? 2'b10 : 2'b01;
                                state_new = ST_S;
                            end
                        end
                        OP_WR: begin
                            state_we  = addr_q[0] ? 2'b10 : 2'b01;
                            state_new = ST_I;
                        end
                        OP_INV: begin
                            state_we     = addr_q[0] ? 2'b10 : 2'b01;
                            state_new    = ST_I;
                            protocol_err = dirty_q;
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

    a_we_onehot: assert property (@(posedge clock) disable iff (!reset_n) $onehot0(state_we));
    a_abort_hs:  assert property (@(posedge clock) disable iff (!reset_n) abort |-> (wb_valid && wb_ready));
    a_done_once: assert property (@(posedge clock) disable iff (!reset_n) snoop_done |=> !snoop_done);

endmodule

// File: tb/tb_bus_snoop_ctrl.sv
// Randomized scoreboard bench for bus_snoop_ctrl: driver pushes expected outcomes
// from a rule-level model, a monitor pops and compares on each completion.
module tb_bus_snoop_ctrl;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] bus_in = '0;
    logic       bus_own = 1'b0;
    logic [1:0] cb0_state = '0, cb1_state = '0;
    logic [2:0] cb0_addr = '0, cb1_addr = '0;
    logic [3:0] cb0_data = '0, cb1_data = '0;
    logic       wb_ready = 1'b0;
    logic       wb_valid, abort, snoop_done, busy, protocol_err;
    logic [2:0] wb_addr;
    logic [3:0] wb_data;
    logic [1:0] state_we, state_new;

    bus_snoop_ctrl dut (
        .clock(clock), .reset_n(reset_n), .bus_in(bus_in), .bus_own(bus_own),
        .cb0_state(cb0_state), .cb1_state(cb1_state),
        .cb0_addr(cb0_addr), .cb1_addr(cb1_addr),
        .cb0_data(cb0_data), .cb1_data(cb1_data),
        .wb_ready(wb_ready), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .state_we(state_we), .state_new(state_new), .abort(abort),
        .snoop_done(snoop_done), .busy(busy), .protocol_err(protocol_err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        bit       wb;
        bit [2:0] a;
        bit [3:0] d;
        bit [1:0] we;
        bit [1:0] nw;
        bit       perr;
        int       acc;
        int       waits;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   wb_seen = 0;

    function automatic void chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Outcome straight from the coherence rules.
    function automatic exp_t model(bit [1:0] op, bit [2:0] a, bit [1:0] st,
                                   bit [2:0] la, bit [3:0] ld, int waits);
        exp_t e;
        bit hit, m;
        hit    = (la == a) && (st == 2'b01 || st == 2'b10);
        m      = hit && (st == 2'b10);
        e.wb   = m && (op != 2'b11);
        e.a    = a;
        e.d    = ld;
        e.perr = m && (op == 2'b11);
        e.we   = 2'b00;
        e.nw   = 2'b00;
        if (hit && !(op == 2'b01 && st == 2'b01)) begin
            e.we = a[0] ? 2'b10 : 2'b01;
            e.nw = (op == 2'b01) ? 2'b01 : 2'b00;
        end
        e.waits = e.wb ? waits : 0;
        e.acc   = 0;
        return e;
    endfunction

    task automatic send(input bit valid, input bit [1:0] op, input bit [2:0] a, input bit own,
                        input bit [1:0] st, input bit [2:0] la, input bit [3:0] ld,
                        input int waits, input bit scramble);
        exp_t e;
        int   w;
        int   k;
        @(posedge clock); #1;
        if (a[0]) begin
            cb1_state = st; cb1_addr = la; cb1_data = ld;
            cb0_state = 2'($urandom); cb0_addr = 3'($urandom); cb0_data = 4'($urandom);
        end else begin
            cb0_state = st; cb0_addr = la; cb0_data = ld;
            cb1_state = 2'($urandom); cb1_addr = 3'($urandom); cb1_data = 4'($urandom);
        end
        bus_in  = {valid, op, a};
        bus_own = own;
        if (!(valid && op != 2'b00 && !own)) begin
            repeat (3) @(posedge clock);
            #1 bus_in = '0; bus_own = 1'b0;
            return;
        end
        e = model(op, a, st, la, ld, waits);
        e.acc = cyc + 1;
        q.push_back(e);
        w = waits;
        for (k = 0; k < 60; k++) begin
            @(posedge clock); #1;
            if (scramble) bus_in = 6'($urandom);
            if (wb_valid) begin
                if (w == 0) wb_ready = 1'b1;
                else begin wb_ready = 1'b0; w--; end
            end else begin
                wb_ready = 1'($urandom);
            end
            if (snoop_done) break;
        end
        if (k == 60) begin
            chk("done_timeout", 0, 1);
            q.delete();
        end
        bus_in   = '0;
        bus_own  = 1'b0;
        wb_ready = 1'b0;
    endtask

    // Reset while a write-back is outstanding; the message must leave no trace.
    task automatic reset_mid_wb();
        exp_t e;
        int   k;
        @(posedge clock); #1;
        cb0_state = 2'b10; cb0_addr = 3'b010; cb0_data = 4'b1010;
        bus_in = {1'b1, 2'b10, 3'b010};
        wb_ready = 1'b0;
        e = model(2'b10, 3'b010, 2'b10, 3'b010, 4'b1010, 0);
        e.acc = cyc + 1;
        q.push_back(e);
        for (k = 0; k < 20; k++) begin
            @(posedge clock); #1;
            if (wb_valid) break;
        end
        chk("rst_wb_reached", int'(wb_valid), 1);
        #2;
        reset_n = 1'b0;
        q.delete();
        bus_in = '0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clock or negedge reset_n);
            if (!reset_n) begin
                #1;
                chk("rst_wb_valid", int'(wb_valid), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_outs", int'({abort, snoop_done, protocol_err, state_we}), 0);
                chk("rst_data", int'({wb_addr, wb_data, state_new}), 0);
                wb_seen = 0;
            end else if (q.size() == 0) begin
                chk("quiet_busy", int'(busy), 0);
                chk("quiet_outs", int'({wb_valid, abort, snoop_done, protocol_err, state_we}), 0);
            end else begin
                chk("abort_hs", int'(abort), int'(wb_valid && wb_ready));
                if (wb_valid && wb_ready) begin
                    chk("wb_expected", 1, int'(q[0].wb));
                    chk("wb_addr", int'(wb_addr), int'(q[0].a));
                    chk("wb_data", int'(wb_data), int'(q[0].d));
                    wb_seen = 1;
                end
                if (!snoop_done) begin
                    chk("early_update", int'({state_we, protocol_err}), 0);
                end else begin
                    e = q.pop_front();
                    chk("state_we", int'(state_we), int'(e.we));
                    chk("state_new", int'(state_new), int'(e.nw));
                    chk("protocol_err", int'(protocol_err), int'(e.perr));
                    chk("wb_happened", int'(wb_seen), int'(e.wb));
                    chk("latency", cyc + 1 - e.acc, e.wb ? 3 + e.waits : 2);
                    wb_seen = 0;
                end
            end
        end
    end

    initial begin
        bit [2:0] a;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;

        send(1, 2'b01, 3'b011, 0, 2'b01, 3'b011, 4'h5, 0, 0);
        send(1, 2'b10, 3'b010, 0, 2'b10, 3'b010, 4'b1010, 2, 0);
        send(1, 2'b01, 3'b100, 0, 2'b10, 3'b100, 4'b0110, 0, 0);
        send(1, 2'b10, 3'b010, 1, 2'b10, 3'b010, 4'b1010, 0, 0);
        send(1, 2'b11, 3'b110, 0, 2'b10, 3'b110, 4'h3, 0, 0);
        send(0, 2'b01, 3'b001, 0, 2'b10, 3'b001, 4'h9, 0, 0);
        send(1, 2'b00, 3'b001, 0, 2'b10, 3'b001, 4'h9, 0, 0);
        send(1, 2'b01, 3'b101, 0, 2'b11, 3'b101, 4'hC, 0, 0);
        send(1, 2'b10, 3'b111, 0, 2'b10, 3'b011, 4'hE, 0, 0);

        reset_mid_wb();
        send(1, 2'b10, 3'b010, 0, 2'b10, 3'b010, 4'b1010, 1, 0);

        for (int i = 0; i < 300; i++) begin
            a = 3'($urandom);
            send(($urandom % 8) != 0, 2'($urandom), a, ($urandom % 6) == 0,
                 2'($urandom), ($urandom % 4 != 0) ? a : 3'($urandom), 4'($urandom),
                 int'($urandom_range(0, 3)), 1'($urandom));
        end

        repeat (3) @(posedge clock);
        chk("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
